// File: rtl/scene_table_writer_pkg.sv
// Shared PPU table layout (sprite/static entry fields, table sizes, button bits)
// and the scene constants used by the table writer.
package scene_table_writer_pkg;

  // Scene geometry
  localparam int STEP      = 2;
  localparam int WORLD_W   = 2047;
  localparam int VIEW_W    = 1024;
  localparam int CAM_MAX   = WORLD_W + 1 - VIEW_W;
  localparam int PLAYER_X0 = 512;
  localparam int ENEMY_XL  = 256;
  localparam int ENEMY_XR  = 768;
  localparam int ENEMY_Y   = 600;

  // Button bit positions inside btn = {up,down,left,right}
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  // Table sizes
  localparam int N_SPRITES = 6;
  localparam int N_STATICS = 6;

  // Sprite entry: {pal, char, y, x}
  localparam int SPR_X_LSB    = 0;
  localparam int SPR_X_W      = 11;
  localparam int SPR_Y_LSB    = SPR_X_LSB + SPR_X_W;
  localparam int SPR_Y_W      = 11;
  localparam int SPR_CHAR_LSB = SPR_Y_LSB + SPR_Y_W;
  localparam int SPR_CHAR_W   = 6;
  localparam int SPR_PAL_LSB  = SPR_CHAR_LSB + SPR_CHAR_W;
  localparam int SPR_PAL_W    = 2;
  localparam int SPR_W        = SPR_PAL_LSB + SPR_PAL_W;

  // Static entry: {pal, char, row, col}
  localparam int ST_COL_LSB  = 0;
  localparam int ST_COL_W    = 7;
  localparam int ST_ROW_LSB  = ST_COL_LSB + ST_COL_W;
  localparam int ST_ROW_W    = 7;
  localparam int ST_CHAR_LSB = ST_ROW_LSB + ST_ROW_W;
  localparam int ST_CHAR_W   = 6;
  localparam int ST_PAL_LSB  = ST_CHAR_LSB + ST_CHAR_W;
  localparam int ST_PAL_W    = 2;
  localparam int ST_W        = ST_PAL_LSB + ST_PAL_W;

  // Axis arithmetic: unsigned coordinates, steps carry one extra sign bit
  localparam int AXIS_W  = SPR_X_W;
  localparam int AXIS_SW = AXIS_W + 1;
  localparam logic [AXIS_SW-1:0] STEP_POS = AXIS_SW'(STEP);
  localparam logic [AXIS_SW-1:0] STEP_NEG = AXIS_SW'(-STEP);
  localparam logic [AXIS_SW-1:0] CAM_STEP = AXIS_SW'(-(VIEW_W / 2));

  typedef logic [SPR_W-1:0] sprite_t;

  function automatic sprite_t make_sprite(input logic [SPR_PAL_W-1:0]  pal,
                                          input logic [SPR_CHAR_W-1:0] chr,
                                          input logic [SPR_Y_W-1:0]    y,
                                          input logic [SPR_X_W-1:0]    x);
    sprite_t s;
    s = '0;
    s[SPR_X_LSB +: SPR_X_W]       = x;
    s[SPR_Y_LSB +: SPR_Y_W]       = y;
    s[SPR_CHAR_LSB +: SPR_CHAR_W] = chr;
    s[SPR_PAL_LSB +: SPR_PAL_W]   = pal;
    return s;
  endfunction

endpackage

// File: rtl/scene_table_writer_axis_step_sat.sv
// Combinational signed step of an unsigned coordinate, saturated to [lo_i, hi_i].
// Zero latency; no flow control.
module axis_step_sat
  import scene_table_writer_pkg::*;
#(
  parameter int W = AXIS_W
) (
  input  logic [W-1:0] val_i,
  input  logic [W:0]   step_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] hi_i,
  output logic [W-1:0] res_o
);

  logic signed [W+1:0] sum;
  logic signed [W+1:0] lo_s;
  logic signed [W+1:0] hi_s;

  // Two guard bits keep val + step exact for any step, so nothing can wrap
  assign sum  = $signed({2'b00, val_i}) + $signed({step_i[W], step_i});
  assign lo_s = $signed({2'b00, lo_i});
  assign hi_s = $signed({2'b00, hi_i});

  always_comb begin
    res_o = sum[W-1:0];
    if (sum < lo_s) begin
      res_o = lo_i;
    end else if (sum > hi_s) begin
      res_o = hi_i;
    end
  end

endmodule

// File: rtl/scene_table_writer.sv
// Per-frame scene producer for the PPU: 6-cycle compute after each vsync fall, tables move only in PACK.
// update follows the synced vsync pulse; static writes are held off (static_ready=0) while publishing.
module scene_table_writer
  import scene_table_writer_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         vsync,
  input  logic [3:0]                   btn,
  input  logic                         static_we,
  input  logic [2:0]                   static_idx,
  input  logic [ST_W-1:0]              static_data,
  output logic                         static_ready,
  output logic                         update,
  output logic [N_SPRITES*SPR_W-1:0]   sprites,
  output logic [N_STATICS*ST_W-1:0]    statics,
  output logic [11:0]                  offset_x,
  output logic [11:0]                  offset_y
);

  localparam logic [2:0] S_WAIT_FALL = 3'd0;
  localparam logic [2:0] S_SAMPLE    = 3'd1;
  localparam logic [2:0] S_MOVE      = 3'd2;
  localparam logic [2:0] S_ENEMY     = 3'd3;
  localparam logic [2:0] S_CAMERA    = 3'd4;
  localparam logic [2:0] S_PACK      = 3'd5;
  localparam logic [2:0] S_READY     = 3'd6;
  localparam logic [2:0] S_PUBLISH   = 3'd7;

  localparam logic [AXIS_W-1:0] POS_LO  = '0;
  localparam logic [AXIS_W-1:0] POS_HI  = AXIS_W'(WORLD_W);
  localparam logic [AXIS_W-1:0] EX_LO   = AXIS_W'(ENEMY_XL);
  localparam logic [AXIS_W-1:0] EX_HI   = AXIS_W'(ENEMY_XR);
  localparam logic [AXIS_W-1:0] CAM_HI  = AXIS_W'(CAM_MAX);
  localparam logic [AXIS_W-1:0] P_START = AXIS_W'(PLAYER_X0);

  localparam logic [SPR_PAL_W-1:0]  PLAYER_PAL  = 2'd0;
  localparam logic [SPR_CHAR_W-1:0] PLAYER_CHAR = 6'd1;
  localparam logic [SPR_PAL_W-1:0]  ENEMY_PAL   = 2'd1;
  localparam logic [SPR_CHAR_W-1:0] ENEMY_CHAR  = 6'd2;

  logic [2:0]  state_q, state_d;
  logic        vs_q, vs_prev_q;
  logic        vs_rise, vs_fall;
  logic [3:0]  btn_q;
  logic [AXIS_W-1:0] px_q, py_q, ex_q;
  logic [AXIS_W-1:0] px_d, py_d, ex_d, camx_d, camy_d;
  logic        edir_q;
  logic [11:0] offx_q, offy_q;
  logic [AXIS_SW-1:0] step_x, step_y, step_e;
  logic        wr_fire;
  logic [N_STATICS*ST_W-1:0]  shadow_q;
  logic [N_SPRITES*SPR_W-1:0] sprites_q, sprites_d;
  logic [N_STATICS*ST_W-1:0]  statics_q;
  logic [11:0] offset_x_q, offset_y_q;

  assign vs_rise = vs_q && !vs_prev_q;
  assign vs_fall = !vs_q && vs_prev_q;

  // Raise update in the very cycle the synced rise is seen so it spans the whole pulse
  assign update       = vs_q && ((state_q == S_PUBLISH) || (state_q == S_READY && !vs_prev_q));
  assign static_ready = (state_q != S_PUBLISH) && !update;
  assign wr_fire      = static_we && static_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_FALL: if (vs_fall) state_d = S_SAMPLE;
      S_SAMPLE:    state_d = S_MOVE;
      S_MOVE:      state_d = S_ENEMY;
      S_ENEMY:     state_d = S_CAMERA;
      S_CAMERA:    state_d = S_PACK;
      S_PACK:      state_d = S_READY;
      S_READY:     if (vs_rise) state_d = S_PUBLISH;
      S_PUBLISH:   if (vs_fall) state_d = S_SAMPLE;
      default:     state_d = S_WAIT_FALL;
    endcase
  end

  // Opposite buttons cancel on their axis
  always_comb begin
    step_x = '0;
    step_y = '0;
    if (btn_q[BTN_RIGHT] && !btn_q[BTN_LEFT]) begin
      step_x = STEP_POS;
    end else if (btn_q[BTN_LEFT] && !btn_q[BTN_RIGHT]) begin
      step_x = STEP_NEG;
    end
    if (btn_q[BTN_DOWN] && !btn_q[BTN_UP]) begin
      step_y = STEP_POS;
    end else if (btn_q[BTN_UP] && !btn_q[BTN_DOWN]) begin
      step_y = STEP_NEG;
    end
  end

  assign step_e = edir_q ? STEP_POS : STEP_NEG;

  axis_step_sat #(.W(AXIS_W)) u_player_x (
    .val_i(px_q), .step_i(step_x), .lo_i(POS_LO), .hi_i(POS_HI), .res_o(px_d)
  );
  axis_step_sat #(.W(AXIS_W)) u_player_y (
    .val_i(py_q), .step_i(step_y), .lo_i(POS_LO), .hi_i(POS_HI), .res_o(py_d)
  );
  axis_step_sat #(.W(AXIS_W)) u_enemy_x (
    .val_i(ex_q), .step_i(step_e), .lo_i(EX_LO), .hi_i(EX_HI), .res_o(ex_d)
  );
  axis_step_sat #(.W(AXIS_W)) u_cam_x (
    .val_i(px_q), .step_i(CAM_STEP), .lo_i(POS_LO), .hi_i(CAM_HI), .res_o(camx_d)
  );
  axis_step_sat #(.W(AXIS_W)) u_cam_y (
    .val_i(py_q), .step_i(CAM_STEP), .lo_i(POS_LO), .hi_i(CAM_HI), .res_o(camy_d)
  );

  // Only the player and enemy slots are live; slots 2-5 are reserved and stay zero
  always_comb begin
    sprites_d = '0;
    sprites_d[0 +: SPR_W]     = make_sprite(PLAYER_PAL, PLAYER_CHAR, py_q, px_q);
    sprites_d[SPR_W +: SPR_W] = make_sprite(ENEMY_PAL, ENEMY_CHAR, SPR_Y_W'(ENEMY_Y), ex_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT_FALL;
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      btn_q      <= '0;
      px_q       <= P_START;
      py_q       <= P_START;
      ex_q       <= EX_LO;
      edir_q     <= 1'b1;
      offx_q     <= '0;
      offy_q     <= '0;
      shadow_q   <= '0;
      sprites_q  <= '0;
      statics_q  <= '0;
      offset_x_q <= '0;
      offset_y_q <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vsync;
      vs_prev_q <= vs_q;

      if (state_q == S_SAMPLE) begin
        btn_q <= btn;
      end
      if (state_q == S_MOVE) begin
        px_q <= px_d;
        py_q <= py_d;
      end
      // A clamped result equal to a bound means the bound was reached or crossed
      if (state_q == S_ENEMY) begin
        ex_q <= ex_d;
        if (edir_q && ex_d == EX_HI) begin
          edir_q <= 1'b0;
        end else if (!edir_q && ex_d == EX_LO) begin
          edir_q <= 1'b1;
        end
      end
      if (state_q == S_CAMERA) begin
        offx_q <= {1'b0, camx_d};
        offy_q <= {1'b0, camy_d};
      end
      if (state_q == S_PACK) begin
        sprites_q  <= sprites_d;
        statics_q  <= shadow_q;
        offset_x_q <= offx_q;
        offset_y_q <= offy_q;
      end

      // Indices 6 and 7 complete the handshake but match no slot
      for (int i = 0; i < N_STATICS; i++) begin
        if (wr_fire && static_idx == 3'(i)) begin
          shadow_q[i*ST_W +: ST_W] <= static_data;
        end
      end
    end
  end

  assign sprites  = sprites_q;
  assign statics  = statics_q;
  assign offset_x = offset_x_q;
  assign offset_y = offset_y_q;

endmodule

// File: tb/tb_scene_table_writer.sv
// Directed bench for scene_table_writer: frames of vsync (L low, H high) with
// hand-computed positions, offsets, static-table contents and update pulse counts.
module tb_scene_table_writer;

  localparam int L = 12;
  localparam int H = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         vsync = 1'b1;
  logic [3:0]   btn = 4'd0;
  logic         static_we = 1'b0;
  logic [2:0]   static_idx = 3'd0;
  logic [21:0]  static_data = 22'd0;
  logic         static_ready;
  logic         update;
  logic [179:0] sprites;
  logic [131:0] statics;
  logic [11:0]  offset_x;
  logic [11:0]  offset_y;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_seen = 0;
  int n_acc    = 0;
  int n_stall  = 0;
  int viol     = 0;
  logic         wr_done   = 1'b0;
  logic         vs_prev_s = 1'b0;
  logic [335:0] snap      = '0;
  logic [131:0] exp_st    = '0;

  always #5 clock = ~clock;

  scene_table_writer dut (
    .clock(clock), .reset(reset), .vsync(vsync), .btn(btn),
    .static_we(static_we), .static_idx(static_idx), .static_data(static_data),
    .static_ready(static_ready), .update(update), .sprites(sprites),
    .statics(statics), .offset_x(offset_x), .offset_y(offset_y)
  );

  task automatic expect_eq(input string tag, input logic [179:0] obs, input logic [179:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // While update is high: vsync (allowing one cycle of sync lag) must be high,
  // the tables must not move, and no static write may be accepted.
  always @(negedge clock) begin
    if (update === 1'b1) begin
      if (!vsync && !vs_prev_s) viol++;
      if ({sprites, statics, offset_x, offset_y} !== snap) viol++;
      if (static_we && static_ready) viol++;
    end
    vs_prev_s = vsync;
    snap = {sprites, statics, offset_x, offset_y};
  end

  task automatic cyc(input logic v);
    @(posedge clock);
    #1;
    vsync = v;
    if (wr_done) begin
      static_we = 1'b0;
      wr_done = 1'b0;
    end
    @(negedge clock);
    if (update) upd_seen++;
    if (static_we) begin
      if (static_ready) begin
        wr_done = 1'b1;
        n_acc++;
      end else begin
        n_stall++;
      end
    end
  endtask

  // low_n low cycles, H high cycles, then one low cycle that carries the trailing update
  task automatic frame(input int low_n, input int exp_upd, input int wr_at,
                       input logic [2:0] idx, input logic [21:0] dat);
    upd_seen = 0;
    for (int i = 0; i < low_n; i++) cyc(1'b0);
    for (int i = 0; i < H; i++) begin
      if (i == wr_at) begin
        static_idx  = idx;
        static_data = dat;
        static_we   = 1'b1;
      end
      cyc(1'b1);
    end
    cyc(1'b0);
    expect_eq("upd_cnt", upd_seen, exp_upd);
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) frame(L, H, -1, 3'd0, 22'd0);
  endtask

  task automatic write_idle(input logic [2:0] idx, input logic [21:0] dat);
    static_idx  = idx;
    static_data = dat;
    static_we   = 1'b1;
  endtask

  initial begin
    // Reset with vsync high, release, check reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    expect_eq("rst_update", update, 0);
    expect_eq("rst_ready", static_ready, 1);
    expect_eq("rst_sprites", sprites, 0);
    expect_eq("rst_statics", statics, 0);
    expect_eq("rst_offx", offset_x, 0);
    expect_eq("rst_offy", offset_y, 0);

    run_frames(2);
    expect_eq("idle_px", sprites[10:0], 512);
    expect_eq("idle_py", sprites[21:11], 512);
    expect_eq("idle_p_char", sprites[27:22], 1);
    expect_eq("idle_p_pal", sprites[29:28], 0);
    expect_eq("idle_offx", offset_x, 0);
    expect_eq("idle_offy", offset_y, 0);
    expect_eq("idle_ex", sprites[40:30], 260);
    expect_eq("idle_ey", sprites[51:41], 600);
    expect_eq("idle_e_char", sprites[57:52], 2);
    expect_eq("idle_e_pal", sprites[59:58], 1);
    expect_eq("reserved_spr", sprites[179:60], 0);

    btn = 4'b0001;
    run_frames(10);
    expect_eq("right10_px", sprites[10:0], 532);
    expect_eq("right10_offx", offset_x, 20);

    btn = 4'b0011;
    run_frames(2);
    expect_eq("lr_px", sprites[10:0], 532);

    btn = 4'b1000;
    run_frames(3);
    expect_eq("up_py", sprites[21:11], 506);
    expect_eq("up_offy_clamp0", offset_y, 0);
    btn = 4'b0100;
    run_frames(3);
    expect_eq("down_py", sprites[21:11], 512);

    btn = 4'b0010;
    run_frames(216);
    expect_eq("left_px100", sprites[10:0], 100);
    expect_eq("left_offx0", offset_x, 0);

    btn = 4'b0001;
    run_frames(973);
    expect_eq("right_px2046", sprites[10:0], 2046);
    expect_eq("right_offx_max", offset_x, 1024);
    run_frames(1);
    expect_eq("sat_px2047", sprites[10:0], 2047);
    run_frames(1);
    expect_eq("sat_px_hold", sprites[10:0], 2047);
    expect_eq("sat_offx_max", offset_x, 1024);

    // Static write issued while publishing must stall until vsync falls
    btn = 4'b0000;
    n_acc = 0;
    n_stall = 0;
    frame(L, H, 2, 3'd3, 22'h2A5F3);
    expect_eq("wr_stalled", n_stall > 0, 1);
    expect_eq("wr_not_yet", statics, exp_st);
    run_frames(1);
    exp_st[87:66] = 22'h2A5F3;
    expect_eq("wr_acc", n_acc, 1);
    expect_eq("wr_idx3", statics, exp_st);

    // idx 7 is accepted and dropped; idx 5 lands in the top slot
    n_acc = 0;
    write_idle(3'd7, 22'h3FFFFF);
    run_frames(2);
    expect_eq("wr7_acc", n_acc, 1);
    expect_eq("wr_idx7_nochg", statics, exp_st);
    n_acc = 0;
    write_idle(3'd5, 22'h15555);
    run_frames(2);
    exp_st[131:110] = 22'h15555;
    expect_eq("wr5_acc", n_acc, 1);
    expect_eq("wr_idx5", statics, exp_st);

    // Rise lands during compute: that frame publishes nothing, the next one does
    frame(3, 0, -1, 3'd0, 22'd0);
    frame(L, H, -1, 3'd0, 22'd0);

    // Reset in the middle of a publish, released while vsync is still high
    for (int i = 0; i < L; i++) cyc(1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    expect_eq("pub_before_rst", update, 1);
    reset = 1'b1;
    #1;
    expect_eq("rst_mid_update", update, 0);
    expect_eq("rst_mid_sprites", sprites, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    cyc(1'b0);
    expect_eq("no_upd_after_rst", upd_seen, 0);
    frame(L, H, -1, 3'd0, 22'd0);
    expect_eq("rst_px", sprites[10:0], 512);
    expect_eq("rst_statics_clr", statics, 0);

    // Enemy: one frame already run since reset, 255 more reach the right bound
    run_frames(255);
    expect_eq("enemy_768", sprites[40:30], 768);
    run_frames(1);
    expect_eq("enemy_766", sprites[40:30], 766);
    run_frames(1);
    expect_eq("enemy_764", sprites[40:30], 764);

    expect_eq("monitor_viol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
